ss_wb_resp: RTL and testbench

//  Wishbone slave responder: the target end of the wbs_* bus driven by the SG
//  DMA master. Serves descriptor fetches and buffer bursts (64-bit beats,
//  8-byte aligned) from a local RAM with programmable wait states and error

---
 rtl/ss_wb_pkg.sv | 20 ++
 rtl/ss_wb_resp_if.sv | 29 ++
 rtl/ss_wb_ram.sv | 21 ++
 rtl/ss_wb_resp.sv | 131 +++++++++++++
 tb/tb_ss_wb_resp.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ss_wb_pkg.sv
// ss_wb_pkg: state encoding, widths and the window check shared by the
// Wishbone responder and its RAM.
package ss_wb_pkg;
  localparam int WORD_W = 64;
  localparam int WCNT_W = 4;
  localparam int PTR_W  = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_GAP,
    ST_ERR,
    ST_RTY
  } state_t;

  function automatic logic in_window(input logic [PTR_W-1:0] ptr, input int aw);
    return (ptr >> aw) == '0;
  endfunction
endpackage

// File: rtl/ss_wb_resp_if.sv
// ss_wb_resp_if: wbs_* bus between the SG DMA master and the responder.
interface ss_wb_resp_if;
  logic        wbs_cyc;
  logic        wbs_stb;
  logic        wbs_we;
  logic        wbs_pref;
  logic        wbs_cab;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat64_i;
  logic [31:0] wbs_dat_o;
  logic [31:0] wbs_dat64_o;
  logic        wbs_ack;
  logic        wbs_err;
  logic        wbs_rty;

  modport master (
    output wbs_cyc, wbs_stb, wbs_we, wbs_pref, wbs_cab, wbs_sel, wbs_adr,
           wbs_dat_i, wbs_dat64_i,
    input  wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_err, wbs_rty
  );

  modport slave (
    input  wbs_cyc, wbs_stb, wbs_we, wbs_pref, wbs_cab, wbs_sel, wbs_adr,
           wbs_dat_i, wbs_dat64_i,
    output wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_err, wbs_rty
  );
endinterface

// File: rtl/ss_wb_ram.sv
// ss_wb_ram: 1R1W synchronous word RAM; a read of the address being written
// returns the old contents.
module ss_wb_ram
  import ss_wb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ss_wb_resp.sv
// ss_wb_resp: Wishbone slave responder serving 64-bit beats from local RAM.
// Build option SS_WB_RTY_EN adds periodic retry injection every RTY_PER requests.
//  state | meaning
//  IDLE  | no cycle in progress
//  WAIT  | counting wait states
//  ACK   | acking beats, one per cycle on bursts
//  GAP   | one idle cycle after a cycle ends
//  ERR   | address outside window
//  RTY   | injected retry
module ss_wb_resp
  import ss_wb_pkg::*;
#(
  parameter int          AW      = 10,
  parameter logic [31:0] BASE    = 32'h0,
  parameter int          WAIT    = 1,
  parameter int          RTY_PER = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  ss_wb_resp_if.slave   bus,
  output logic [15:0]   beat_cnt
);
  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, ptr_nx, ptr_inc, adr_word;
  logic [WCNT_W-1:0]  wcnt, wcnt_nx;
  logic [AW-1:0]      rd_addr;
  logic [WORD_W-1:0]  rd_data;
  logic               req, beat, ram_we;
  logic               rty_new, rty_pend;
  logic               unused_bits;

  assign req      = bus.wbs_cyc & bus.wbs_stb;
  assign beat     = (state == ST_ACK) & req;
  assign ram_we   = beat & bus.wbs_we & wb_rst_n;
  assign adr_word = bus.wbs_adr[31:3] - BASE[31:3];
  assign ptr_inc  = ptr + 1'b1;
  assign unused_bits = ^{bus.wbs_sel, bus.wbs_pref, bus.wbs_adr[2:0], RTY_PER > 0};

  function automatic state_t first_beat(input logic [PTR_W-1:0] p, input logic rty);
    if (rty) return ST_RTY;
    if (!in_window(p, AW)) return ST_ERR;
    return ST_ACK;
  endfunction

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    wcnt_nx  = wcnt;
    rd_addr  = ptr[AW-1:0];
    if (!bus.wbs_cyc) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          rd_addr = adr_word[AW-1:0];
          if (bus.wbs_stb) begin
            ptr_nx   = adr_word;
            wcnt_nx  = WCNT_W'(WAIT);
            state_nx = (WAIT == 0) ? first_beat(adr_word, rty_new) : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wcnt_nx = wcnt - 1'b1;
          if (wcnt_nx == '0) state_nx = first_beat(ptr, rty_pend);
        end
        ST_ACK: begin
          // fetch the following word on the ack edge so bursts have no bubbles
          if (bus.wbs_stb) begin
            rd_addr = ptr_inc[AW-1:0];
            ptr_nx  = ptr_inc;
            if (!bus.wbs_cab)                state_nx = ST_GAP;
            else if (!in_window(ptr_inc, AW)) state_nx = ST_ERR;
          end
        end
        ST_ERR:  state_nx = ST_GAP;
        ST_RTY:  state_nx = ST_GAP;
        ST_GAP:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      wcnt     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      wcnt  <= wcnt_nx;
      if (beat && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 1'b1;
    end
  end

`ifdef SS_WB_RTY_EN
  logic [15:0] req_cnt;

  assign rty_new = (req_cnt == 16'(RTY_PER - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      req_cnt  <= '0;
      rty_pend <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      req_cnt  <= rty_new ? 16'h0 : req_cnt + 1'b1;
      rty_pend <= rty_new;
    end
  end

  assign bus.wbs_rty = (state == ST_RTY) & req;
`else
  assign rty_new     = 1'b0;
  assign rty_pend    = 1'b0;
  assign bus.wbs_rty = 1'b0;
`endif

  assign bus.wbs_ack = beat;
  assign bus.wbs_err = (state == ST_ERR) & req;
  assign {bus.wbs_dat64_o, bus.wbs_dat_o} = beat ? rd_data : '0;

  ss_wb_ram #(.AW(AW)) u_ram (
    .clk     (wb_clk_i),
    .we      (ram_we),
    .wr_addr (ptr[AW-1:0]),
    .wr_data ({bus.wbs_dat64_i, bus.wbs_dat_i}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_ss_wb_resp.sv
// tb_ss_wb_resp: scoreboard bench for ss_wb_resp; expected responses are
// queued as beats are driven and popped when ack/err/rty appears.
module tb_ss_wb_resp;
  localparam int AW      = 6;
  localparam int DEPTH   = 64;
  localparam int WAIT    = 1;
  localparam int RTY_PER = 2;

  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] data;
  } exp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [15:0] beat_cnt;

  ss_wb_resp_if bus();

  ss_wb_resp #(.AW(AW), .BASE(32'h0), .WAIT(WAIT), .RTY_PER(RTY_PER)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .bus      (bus),
    .beat_cnt (beat_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  exp_t        sb_q[$];
  logic [63:0] mem_m [DEPTH];
  int n_chk = 0, n_bad = 0;
  int exp_beats = 0, req_m = 0;
  int r_acks, r_errs, r_rtys, r_lat, r_gaps;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit next_is_rty();
`ifdef SS_WB_RTY_EN
    req_m++;
    if (req_m == RTY_PER) begin
      req_m = 0;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic bus_idle();
    bus.wbs_cyc = 0; bus.wbs_stb = 0; bus.wbs_we = 0; bus.wbs_pref = 0;
    bus.wbs_cab = 0; bus.wbs_sel = 4'h0; bus.wbs_adr = '0;
    bus.wbs_dat_i = '0; bus.wbs_dat64_i = '0;
  endtask

  task automatic pulse_reset();
    bus_idle();
    wb_rst_n = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_n = 1'b1;
    req_m = 0;
    exp_beats = 0;
  endtask

  task automatic drive_beat(input int w, input logic we, input logic cab,
                            input logic [63:0] wd, input bit rty);
    exp_t e;
    bus.wbs_cyc = 1; bus.wbs_stb = 1; bus.wbs_we = we; bus.wbs_cab = cab;
    bus.wbs_pref = ~we; bus.wbs_sel = 4'hF;
    bus.wbs_adr = 32'(w) << 3;
    {bus.wbs_dat64_i, bus.wbs_dat_i} = wd;
    e.kind = rty ? K_RTY : (w < DEPTH) ? K_ACK : K_ERR;
    e.data = (w < DEPTH) ? mem_m[w] : 64'h0;
    sb_q.push_back(e);
  endtask

  // One master cycle: n beats (stop early after stop_after acks), optional
  // synchronous reset asserted right after rst_after acks.
  task automatic xfer(input logic we, input int word, input int n, input logic cab,
                      input int stop_after, input int rst_after, input logic [63:0] wbase);
    int beat, ncyc;
    bit done, rty;
    logic [2:0] got;
    exp_t e;
    beat = 0; ncyc = 0; done = 0;
    r_acks = 0; r_errs = 0; r_rtys = 0; r_lat = -1; r_gaps = 0;
    rty = next_is_rty();
    @(posedge wb_clk_i); #1;
    drive_beat(word, we, cab, wbase, rty);
    while (!done) begin
      @(negedge wb_clk_i);
      ncyc++;
      got = {bus.wbs_ack, bus.wbs_err, bus.wbs_rty};
      if (got != 3'b000) begin
        if (r_lat < 0) r_lat = ncyc - 1;
        if (sb_q.size() == 0) begin
          chk("sb_extra", 64'(got), 64'(0));
          done = 1;
        end else begin
          e = sb_q.pop_front();
          chk("resp_kind", 64'(got), 64'(e.kind));
          if (got == K_ACK) begin
            if (!we) chk("rdata", {bus.wbs_dat64_o, bus.wbs_dat_o}, e.data);
            else if (e.kind == K_ACK && word + beat < DEPTH) mem_m[word+beat] = wbase + 64'(beat);
            r_acks++;
            beat++;
            exp_beats++;
          end else begin
            if (got == K_ERR) r_errs++;
            else r_rtys++;
            done = 1;
          end
        end
      end else if (r_acks > 0) begin
        r_gaps++;
      end
      if (beat >= n || beat >= stop_after) done = 1;
      if (ncyc >= 40) begin
        chk("timeout", 64'(ncyc), 64'(0));
        done = 1;
      end
      if (rst_after > 0 && beat == rst_after) begin
        wb_rst_n = 1'b0;
        @(negedge wb_clk_i);
        chk("rst_ack", 64'(bus.wbs_ack), 64'(0));
        chk("rst_err", 64'(bus.wbs_err), 64'(0));
        chk("rst_dat", {bus.wbs_dat64_o, bus.wbs_dat_o}, 64'(0));
        chk("rst_beats", 64'(beat_cnt), 64'(0));
        wb_rst_n = 1'b1;
        bus_idle();
        sb_q.delete();
        exp_beats = 0;
        req_m = 0;
        return;
      end
      @(posedge wb_clk_i); #1;
      if (done) bus_idle();
      else if (got == K_ACK) drive_beat(word + beat, we, cab, wbase + 64'(beat), 1'b0);
    end
    chk("sb_left", 64'(sb_q.size()), 64'(0));
    sb_q.delete();
  endtask

  // Re-issues a cycle that was answered with a retry.
  task automatic do_xfer(input logic we, input int word, input int n, input logic cab,
                         input int stop_after, input int rst_after, input logic [63:0] wbase);
    for (int t = 0; t < 3; t++) begin
      xfer(we, word, n, cab, stop_after, rst_after, wbase);
      if (r_rtys == 0) break;
    end
  endtask

  initial begin
    bus_idle();
    wb_rst_n = 1'b0;
    bus.wbs_cyc = 1; bus.wbs_stb = 1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("reset_ack", 64'(bus.wbs_ack), 64'(0));
    chk("reset_err", 64'(bus.wbs_err), 64'(0));
    chk("reset_rty", 64'(bus.wbs_rty), 64'(0));
    chk("reset_dat", {bus.wbs_dat64_o, bus.wbs_dat_o}, 64'(0));
    chk("reset_beats", 64'(beat_cnt), 64'(0));
    pulse_reset();

    // descriptor fetch
    do_xfer(1, 4, 1, 0, 99, 0, 64'h0000_2000_0010_0008);
    do_xfer(1, 5, 1, 0, 99, 0, 64'hCAFE_0005_BEEF_0005);
    do_xfer(0, 4, 2, 1, 99, 0, 64'h0);
    chk("desc_lat", 64'(r_lat), 64'(WAIT + 1));
    chk("desc_gaps", 64'(r_gaps), 64'(0));
    chk("desc_acks", 64'(r_acks), 64'(2));
    chk("desc_beats", 64'(beat_cnt), 64'(exp_beats));

    // 8-beat write burst at 0x100 after a fresh reset
    pulse_reset();
    do_xfer(1, 32, 8, 1, 99, 0, 64'h0);
    chk("wburst_acks", 64'(r_acks), 64'(8));
    chk("wburst_beats", 64'(beat_cnt), 64'(8));
    do_xfer(0, 32, 8, 1, 99, 0, 64'h0);
    chk("rburst_acks", 64'(r_acks), 64'(8));
    chk("rburst_gaps", 64'(r_gaps), 64'(0));

    // window boundary
    do_xfer(1, 0, 1, 0, 99, 0, 64'h0123_4567_89AB_CDEF);
    do_xfer(1, 63, 1, 0, 99, 0, 64'h6363_6363_0000_003F);
    do_xfer(0, 64, 1, 0, 99, 0, 64'h0);
    chk("oow_rd_err", 64'(r_errs), 64'(1));
    chk("oow_rd_ack", 64'(r_acks), 64'(0));
    chk("oow_rd_lat", 64'(r_lat), 64'(WAIT + 1));
    do_xfer(1, 64, 1, 0, 99, 0, 64'hDEAD_DEAD_DEAD_DEAD);
    chk("oow_wr_err", 64'(r_errs), 64'(1));
    do_xfer(1, 62, 4, 1, 99, 0, 64'h7777_0000_0000_0000);
    chk("cross_wr_acks", 64'(r_acks), 64'(2));
    chk("cross_wr_err", 64'(r_errs), 64'(1));
    do_xfer(0, 0, 1, 0, 99, 0, 64'h0);
    chk("alias_intact", 64'(r_acks), 64'(1));
    do_xfer(0, 63, 2, 1, 99, 0, 64'h0);
    chk("last_acks", 64'(r_acks), 64'(1));
    chk("last_err", 64'(r_errs), 64'(1));
    chk("edge_beats", 64'(beat_cnt), 64'(exp_beats));

    // master abandons a write burst after 3 beats
    do_xfer(1, 16, 8, 1, 99, 0, 64'hAAAA_0000_0000_0000);
    do_xfer(1, 16, 8, 1, 3, 0, 64'hBBBB_0000_0000_0000);
    chk("drop_acks", 64'(r_acks), 64'(3));
    do_xfer(0, 16, 8, 1, 99, 0, 64'h0);
    chk("drop_rd_acks", 64'(r_acks), 64'(8));
    chk("drop_rd_lat", 64'(r_lat), 64'(WAIT + 1));

    // reset in the middle of a read burst; RAM keeps earlier writes
    do_xfer(1, 8, 3, 1, 99, 0, 64'h5555_0000_0000_0008);
    do_xfer(0, 8, 4, 1, 99, 2, 64'h0);
    do_xfer(0, 8, 3, 1, 99, 0, 64'h0);
    chk("post_rst_acks", 64'(r_acks), 64'(3));
    chk("post_rst_beats", 64'(beat_cnt), 64'(3));

    // retry injection: second request after reset
    pulse_reset();
    xfer(0, 4, 1, 0, 99, 0, 64'h0);
    chk("req1_acks", 64'(r_acks), 64'(1));
    xfer(0, 5, 1, 0, 99, 0, 64'h0);
`ifdef SS_WB_RTY_EN
    chk("req2_rty", 64'(r_rtys), 64'(1));
    chk("req2_acks", 64'(r_acks), 64'(0));
    chk("req2_lat", 64'(r_lat), 64'(WAIT + 1));
`else
    chk("req2_rty", 64'(r_rtys), 64'(0));
    chk("req2_acks", 64'(r_acks), 64'(1));
`endif
    xfer(0, 5, 1, 0, 99, 0, 64'h0);
    chk("req3_acks", 64'(r_acks), 64'(1));
    chk("final_beats", 64'(beat_cnt), 64'(exp_beats));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
